// File: rtl/bcd_serial_addsub.sv
// Digit-serial BCD adder/subtractor: one decimal digit per clock, LSD first.
// Optional non-BCD input detection is built when BCD_DIGIT_CHECK_EN is defined.
module bcd_serial_addsub #(
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  sub,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  cin,
    output logic [4*DIGITS-1:0]   s,
    output logic                  cout,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state, state_nxt;
    logic [W-1:0]  a_sh, b_sh;
    logic          sub_r;
    logic          carry;
    logic [CW-1:0] cnt;
    logic          last;

    logic [3:0]    a_dig, b_dig;
    logic [4:0]    t, t_adj;
    logic [3:0]    s_dig;
    logic          c_nxt;

    assign last = (cnt == '0);
    assign busy = (state == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Shared per-digit correction stage; subtraction uses the nines' complement of b.
    always_comb begin
        a_dig = a_sh[3:0];
        b_dig = sub_r ? (4'd9 - b_sh[3:0]) : b_sh[3:0];
        t     = {1'b0, a_dig} + {1'b0, b_dig} + {4'b0000, carry};
        t_adj = t + 5'd6;
        s_dig = t[3:0];
        c_nxt = 1'b0;
        if (t > 5'd9) begin
            s_dig = t_adj[3:0];
            c_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            sub_r <= 1'b0;
            carry <= 1'b0;
            cnt   <= '0;
            s     <= '0;
            cout  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        sub_r <= sub;
                        carry <= sub ? ~cin : cin;
                        cnt   <= CW'(DIGITS - 1);
                        s     <= '0;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 4;
                    b_sh  <= b_sh >> 4;
                    carry <= c_nxt;
                    cnt   <= cnt - 1'b1;
                    // New digit enters at the top so the word is aligned after the last digit.
                    s     <= (s >> 4) | (W'(s_dig) << (W - 4));
                    if (last) begin
                        cout <= sub_r ? ~c_nxt : c_nxt;
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef BCD_DIGIT_CHECK_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (state == IDLE) begin
            if (start) err_q <= 1'b0;
        end else if ((a_sh[3:0] > 4'd9) || (b_sh[3:0] > 4'd9)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Directed self-checking bench for bcd_serial_addsub with DIGITS=3.
module tb_bcd_serial_addsub;

    localparam int D = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          sub = 1'b0;
    logic [4*D-1:0] a = '0;
    logic [4*D-1:0] b = '0;
    logic          cin = 1'b0;
    logic [4*D-1:0] s;
    logic          cout, busy, done, err;

    int n_cmp = 0;
    int n_bad = 0;

    bcd_serial_addsub #(.DIGITS(D)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub),
        .a(a), .b(b), .cin(cin), .s(s), .cout(cout),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Launch one operation and wait (bounded) for done; lat counts edges after acceptance.
    task automatic do_op(input logic [11:0] av, input logic [11:0] bv, input logic sv,
                         input logic cv, output int lat);
        @(negedge clk);
        a = av; b = bv; sub = sv; cin = cv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({s, cout, busy, done, err} !== 16'h0) begin
            n_bad++;
            $display("FAIL reset_state: got s=%h cout=%b busy=%b done=%b err=%b, want all 0",
                     s, cout, busy, done, err);
        end
    endtask

    task automatic test_add();
        int lat;
        // first vector checked edge by edge for busy and latency
        @(negedge clk);
        a = 12'h100; b = 12'h225; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                n_bad++;
                $display("FAIL add_busy[%0d]: got busy=%b done=%b, want busy=1 done=0", i, busy, done);
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0 || s !== 12'h325 || cout !== 1'b0) begin
            n_bad++;
            $display("FAIL add_100_225: got done=%b busy=%b s=%h cout=%b, want 1 0 325 0",
                     done, busy, s, cout);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (done !== 1'b0 || s !== 12'h325 || cout !== 1'b0) begin
            n_bad++;
            $display("FAIL done_pulse_hold: got done=%b s=%h cout=%b, want 0 325 0", done, s, cout);
        end

        do_op(12'h999, 12'h999, 1'b0, 1'b0, lat);
        n_cmp++;
        if (lat !== 3 || s !== 12'h998 || cout !== 1'b1) begin
            n_bad++;
            $display("FAIL add_999_999_c0: got lat=%0d s=%h cout=%b, want 3 998 1", lat, s, cout);
        end
        do_op(12'h999, 12'h999, 1'b0, 1'b1, lat);
        n_cmp++;
        if (lat !== 3 || s !== 12'h999 || cout !== 1'b1) begin
            n_bad++;
            $display("FAIL add_999_999_c1: got lat=%0d s=%h cout=%b, want 3 999 1", lat, s, cout);
        end
    endtask

    task automatic test_sub();
        int lat;
        do_op(12'h325, 12'h100, 1'b1, 1'b0, lat);
        n_cmp++;
        if (lat !== 3 || s !== 12'h225 || cout !== 1'b0) begin
            n_bad++;
            $display("FAIL sub_325_100: got lat=%0d s=%h cout=%b, want 3 225 0", lat, s, cout);
        end
        do_op(12'h100, 12'h225, 1'b1, 1'b0, lat);
        n_cmp++;
        if (lat !== 3 || s !== 12'h875 || cout !== 1'b1) begin
            n_bad++;
            $display("FAIL sub_100_225: got lat=%0d s=%h cout=%b, want 3 875 1", lat, s, cout);
        end
        do_op(12'h000, 12'h000, 1'b1, 1'b1, lat);
        n_cmp++;
        if (lat !== 3 || s !== 12'h999 || cout !== 1'b1) begin
            n_bad++;
            $display("FAIL sub_0_0_b1: got lat=%0d s=%h cout=%b, want 3 999 1", lat, s, cout);
        end
    endtask

    task automatic test_ignore_start();
        int lat;
        @(negedge clk);
        a = 12'h100; b = 12'h225; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        a = 12'h999;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        n_cmp++;
        if (lat !== 3 || s !== 12'h325 || cout !== 1'b0) begin
            n_bad++;
            $display("FAIL ignore_start: got lat=%0d s=%h cout=%b, want 3 325 0", lat, s, cout);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL ignore_start_idle: got busy=%b, want 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        do_op(12'h123, 12'h456, 1'b0, 1'b0, lat);
        n_cmp++;
        if (lat !== 3 || s !== 12'h579) begin
            n_bad++;
            $display("FAIL b2b_first: got lat=%0d s=%h, want 3 579", lat, s);
        end
        // done is high right now; a start here must be taken
        a = 12'h001; b = 12'h001; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        n_cmp++;
        if (lat !== 3 || s !== 12'h002 || cout !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_second: got lat=%0d s=%h cout=%b, want 3 002 0", lat, s, cout);
        end
    endtask

    task automatic test_reset_abort();
        int lat;
        int seen;
        @(negedge clk);
        a = 12'h100; b = 12'h225; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (s !== 12'h000 || cout !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_reset: got s=%h cout=%b busy=%b done=%b, want 000 0 0 0",
                     s, cout, busy, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_bad++;
            $display("FAIL abort_no_done: got %0d cycles with done/busy, want 0", seen);
        end
        do_op(12'h047, 12'h038, 1'b0, 1'b0, lat);
        n_cmp++;
        if (lat !== 3 || s !== 12'h085 || cout !== 1'b0) begin
            n_bad++;
            $display("FAIL after_reset_op: got lat=%0d s=%h cout=%b, want 3 085 0", lat, s, cout);
        end
    endtask

    task automatic test_err();
        int   lat;
        logic exp_err;
`ifdef BCD_DIGIT_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        do_op(12'h00A, 12'h000, 1'b0, 1'b0, lat);
        n_cmp++;
        if (lat !== 3 || err !== exp_err || s !== 12'h010) begin
            n_bad++;
            $display("FAIL err_bad_digit: got lat=%0d err=%b s=%h, want 3 %b 010", lat, err, s, exp_err);
        end
        do_op(12'h001, 12'h002, 1'b0, 1'b0, lat);
        n_cmp++;
        if (lat !== 3 || err !== 1'b0 || s !== 12'h003) begin
            n_bad++;
            $display("FAIL err_cleared: got lat=%0d err=%b s=%h, want 3 0 003", lat, err, s);
        end
    endtask

    initial begin
        #12;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_add();
        test_sub();
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
        test_err();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
